// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles the fetch unit's three conversations: the synchronous
//   instruction ROM port, the valid/ready output to decode, and the
//   branch/jump redirect request.
//   master : fetch unit side (drives ROM address/enable and decode outputs)
//   slave  : environment side (ROM data, decode ready, redirect request)
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  // ROM port
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_instruct;
  // Decode handshake
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instruct;
  logic [ADDR_WIDTH-1:0] out_pc;
  // Redirect request
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output mem_read_en, mem_addr, out_valid, out_instruct, out_pc,
    input  mem_instruct, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_read_en, mem_addr, out_valid, out_instruct, out_pc,
    output mem_instruct, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Program counter and fetch stage in front of a synchronous instruction
//   ROM. Each issued read lands in the ROM output register one cycle later
//   and is presented to decode, tagged with its address, over valid/ready.
//   Backpressure is absorbed by the ROM itself: with read enable low its
//   output register holds, so no skid buffer is needed here.
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous, active-high reset
//   fetch_en : when low, no new ROM reads are issued
//   bus      : fetch_unit_if.master (ROM port, decode handshake, redirect)
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  fetch_unit_if.master  bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [ADDR_WIDTH-1:0] pc_q,      pc_d;
  logic [0:0]            pend_q,    pend_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  issue;
  logic                  xfer;

  // A new read may go out when the ROM register is free or is being
  // drained this cycle; otherwise issuing would overwrite a live instruction.
  assign issue = fetch_en & ((pend_q == ST_EMPTY) | bus.out_ready);
  // Redirect kills the handshake in its own cycle, so the discarded
  // instruction can never be consumed.
  assign xfer  = (pend_q == ST_FULL) & bus.out_ready & ~bus.redirect_valid;

  always_comb begin
    bus.mem_read_en = 1'b0;
    bus.mem_addr    = pc_q;
    if (bus.redirect_valid) begin
      bus.mem_addr    = bus.redirect_pc;
      bus.mem_read_en = fetch_en;
    end else begin
      bus.mem_read_en = issue;
    end
    if (rst) begin
      bus.mem_read_en = 1'b0;
    end
  end

  assign bus.out_valid    = (pend_q == ST_FULL) & ~bus.redirect_valid;
  assign bus.out_pc       = pend_pc_q;
  assign bus.out_instruct = bus.mem_instruct;

  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (bus.redirect_valid) begin
      if (fetch_en) begin
        pc_d      = bus.redirect_pc + ADDR_WIDTH'(1);
        pend_d    = ST_FULL;
        pend_pc_d = bus.redirect_pc;
      end else begin
        pc_d   = bus.redirect_pc;
        pend_d = ST_EMPTY;
      end
    end else if (issue) begin
      // Natural modulo-2^ADDR_WIDTH wrap of the adder is intended.
      pc_d      = pc_q + ADDR_WIDTH'(1);
      pend_d    = ST_FULL;
      pend_pc_d = pc_q;
    end else if (xfer) begin
      pend_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_q    <= ST_EMPTY;
      pend_pc_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk;
  logic rst;
  logic fetch_en;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(16'h0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: ROM[a] = 16'h1000 + a, registered, holds while read enable low.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return DW'(16'h1000 + a);
  endfunction

  logic [DW-1:0] rom_q;
  always @(posedge clk) begin
    if (bus.mem_read_en) rom_q <= rom_f(bus.mem_addr);
  end
  assign bus.mem_instruct = rom_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } xfer_t;

  xfer_t exp_q[$];

  task automatic push_exp(input logic [AW-1:0] pc);
    xfer_t e;
    e.pc  = pc;
    e.ins = rom_f(pc);
    exp_q.push_back(e);
  endtask

  // Transfers are sampled mid-cycle; the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_xfer_pc", 32'(bus.out_pc), 32'hFFFF_FFFF);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check_val("xfer_pc", 32'(bus.out_pc), 32'(e.pc));
        check_val("xfer_ins", 32'(bus.out_instruct), 32'(e.ins));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs until the scoreboard empties; with ready held high each entry
  // must take exactly one cycle (no bubbles).
  task automatic drain(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check_val({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    fetch_en           = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) step();
    @(negedge clk);
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_rden", 32'(bus.mem_read_en), 32'd0);
    check_val("rst_addr", 32'(bus.mem_addr), 32'd0);
    check_val("rst_pc", 32'(bus.out_pc), 32'd0);

    // Reset then stream
    step();
    rst           = 1'b0;
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val("first_rden", 32'(bus.mem_read_en), 32'd1);
    check_val("first_addr", 32'(bus.mem_addr), 32'd0);
    check_val("first_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 5; i++) push_exp(AW'(i));
    step();
    drain("stream", 5);

    // Stall with pc 5 on display
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stall_valid", 32'(bus.out_valid), 32'd1);
      check_val("stall_pc", 32'(bus.out_pc), 32'd5);
      check_val("stall_ins", 32'(bus.out_instruct), 32'h1005);
      check_val("stall_rden", 32'(bus.mem_read_en), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    push_exp(16'd5);
    push_exp(16'd6);
    drain("unstall", 2);

    // Redirect while pc 7 is valid
    check_val("pre_redir_pc", 32'(bus.out_pc), 32'd7);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0040;
    push_exp(16'h0040);
    push_exp(16'h0041);
    @(negedge clk);
    check_val("redir_valid", 32'(bus.out_valid), 32'd0);
    check_val("redir_rden", 32'(bus.mem_read_en), 32'd1);
    check_val("redir_addr", 32'(bus.mem_addr), 32'h0040);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check_val("redir_tgt_valid", 32'(bus.out_valid), 32'd1);
    #1;
    drain("redir", 2);

    // Halt: pending 0042 still accepted, then nothing
    fetch_en = 1'b0;
    push_exp(16'h0042);
    @(negedge clk);
    check_val("halt_rden", 32'(bus.mem_read_en), 32'd0);
    check_val("halt_valid", 32'(bus.out_valid), 32'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("halted_valid", 32'(bus.out_valid), 32'd0);
      check_val("halted_rden", 32'(bus.mem_read_en), 32'd0);
      step();
    end
    check_val("halt_left", 32'(exp_q.size()), 32'd0);
    fetch_en = 1'b1;
    @(negedge clk);
    check_val("resume_rden", 32'(bus.mem_read_en), 32'd1);
    check_val("resume_addr", 32'(bus.mem_addr), 32'h0043);
    push_exp(16'h0043);
    push_exp(16'h0044);
    step();
    drain("resume", 2);

    // Wrap through the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    push_exp(16'h0001);
    step();
    bus.redirect_valid = 1'b0;
    drain("wrap", 4);

    // Asynchronous reset in the middle of a stall
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_val("mstall_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_rden", 32'(bus.mem_read_en), 32'd0);
    check_val("arst_pc", 32'(bus.out_pc), 32'd0);
    step();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_val("restart_rden", 32'(bus.mem_read_en), 32'd1);
    check_val("restart_addr", 32'(bus.mem_addr), 32'd0);
    check_val("restart_valid", 32'(bus.out_valid), 32'd0);
    push_exp(16'd0);
    push_exp(16'd1);
    push_exp(16'd2);
    step();
    drain("restart", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
